// File: rtl/axis_echo.sv
`default_nettype none
// ============================================================================
// Module   : axis_echo
// Purpose  : AXI-Stream stereo echo with feedback through a single-port delay RAM.
// Revision : 1.0
// ============================================================================
module axis_echo #(
    parameter int DATA_WIDTH   = 24,
    parameter int DELAY_FRAMES = 4096,
    parameter int DECAY_SHIFT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  echo_sw,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last
);

    localparam int c_DEPTH = 2 * DELAY_FRAMES;
    localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

    localparam logic [c_AW-1:0]       c_LAST_ADDR = c_AW'(c_DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] c_SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_SAT_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] c_S_CLEAR = 2'd0;
    localparam logic [1:0] c_S_IDLE  = 2'd1;
    localparam logic [1:0] c_S_READ  = 2'd2;
    localparam logic [1:0] c_S_OUT   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_AW-1:0]       r_ptr;
    logic [c_AW-1:0]       r_clr_cnt;
    logic                  r_s_ready;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic [DATA_WIDTH-1:0] r_in;
    logic                  r_last;
    logic                  r_sw;
    logic [DATA_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_s_hs;
    logic                  w_mem_we;
    logic [c_AW-1:0]       w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic signed [DATA_WIDTH-1:0] w_rd_shift;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_sat;
    logic [DATA_WIDTH-1:0] w_out;

    assign s_axis_ready = r_s_ready;
    assign m_axis_valid = r_m_valid;
    assign m_axis_data  = r_m_data;
    assign m_axis_last  = r_m_last;

    assign w_s_hs = r_s_ready & s_axis_valid;

    // One extra bit of headroom so overflow shows up as a sign disagreement.
    assign w_rd_shift = $signed(r_rd) >>> DECAY_SHIFT;
    assign w_sum      = {r_in[DATA_WIDTH-1], r_in} + {w_rd_shift[DATA_WIDTH-1], w_rd_shift};

    always_comb begin
        w_sat = w_sum[DATA_WIDTH-1:0];
        if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
            w_sat = w_sum[DATA_WIDTH] ? c_SAT_MIN : c_SAT_MAX;
        end
    end

    assign w_out = r_sw ? w_sat : r_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_ptr;
        w_mem_wdata = '0;
        case (r_state)
            c_S_CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt;
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_IDLE: begin
                if (w_s_hs) begin
                    w_state_nxt = c_S_READ;
                end
            end
            c_S_READ: begin
                // Bypassed samples store zero so old echo is flushed out.
                w_mem_we    = 1'b1;
                w_mem_wdata = r_sw ? w_out : '0;
                w_state_nxt = c_S_OUT;
            end
            c_S_OUT: begin
                if (m_axis_ready) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_ptr     <= '0;
            r_clr_cnt <= '0;
            r_in      <= '0;
            r_last    <= 1'b0;
            r_sw      <= 1'b0;
        end else begin
            r_s_ready <= (w_state_nxt == c_S_IDLE);
            case (r_state)
                c_S_CLEAR: begin
                    r_clr_cnt <= (r_clr_cnt == c_LAST_ADDR) ? '0 : r_clr_cnt + 1'b1;
                end
                c_S_IDLE: begin
                    if (w_s_hs) begin
                        r_in   <= s_axis_data;
                        r_last <= s_axis_last;
                        r_sw   <= echo_sw;
                    end
                end
                c_S_READ: begin
                    r_m_data  <= w_out;
                    r_m_last  <= r_last;
                    r_m_valid <= 1'b1;
                    r_ptr     <= (r_ptr == c_LAST_ADDR) ? '0 : r_ptr + 1'b1;
                end
                c_S_OUT: begin
                    if (m_axis_ready) begin
                        r_m_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single-port RAM: the read of RAM[ptr] issued in IDLE is ready in READ.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end else begin
            r_rd <= r_mem[w_mem_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_echo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_echo
// Purpose  : Directed and randomized checks of axis_echo against a sample-history model.
// Revision : 1.0
// ============================================================================
module tb_axis_echo;

    localparam int DW    = 24;
    localparam int DF    = 2;
    localparam int DS    = 1;
    localparam int DEPTH = 2 * DF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          echo_sw = 1'b0;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic          s_axis_last = 1'b0;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b0;
    logic          m_axis_last;

    int checks = 0;
    int errors = 0;
    int hist[$];

    axis_echo #(
        .DATA_WIDTH  (DW),
        .DELAY_FRAMES(DF),
        .DECAY_SHIFT (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .echo_sw     (echo_sw),
        .s_axis_data (s_axis_data),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .s_axis_last (s_axis_last),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_last (m_axis_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output n = input n + (stored output n-DEPTH)/2^DS, clamped; bypass stores 0.
    function automatic int model_next(input logic [DW-1:0] d, input logic sw);
        int x;
        int prev;
        int y;
        x    = int'($signed(d));
        prev = (hist.size() >= DEPTH) ? hist[hist.size() - DEPTH] : 0;
        y    = x;
        if (sw) begin
            y = x + (prev >>> DS);
            if (y > 8388607) y = 8388607;
            else if (y < -8388608) y = -8388608;
        end
        hist.push_back(sw ? y : 0);
        return y;
    endfunction

    task automatic push(input logic [DW-1:0] d, input logic l, input logic sw, input int stall);
        logic [DW-1:0] e;
        int n;
        e = DW'(model_next(d, sw));
        s_axis_data  = d;
        s_axis_last  = l;
        echo_sw      = sw;
        s_axis_valid = 1'b1;
        n = 0;
        while (!s_axis_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_ready) begin
            chk("in_ready_timeout", 32'(s_axis_ready), 32'd1);
            s_axis_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (stall > 0) s_axis_data = 24'h555555;
        else s_axis_valid = 1'b0;
        @(negedge clk);
        chk("lat_read", 32'(m_axis_valid), 32'd0);
        @(negedge clk);
        chk("lat_out", 32'(m_axis_valid), 32'd1);
        chk("data", 32'(m_axis_data), 32'(e));
        chk("last", 32'(m_axis_last), 32'(l));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(m_axis_valid), 32'd1);
            chk("stall_data", 32'(m_axis_data), 32'(e));
            chk("stall_last", 32'(m_axis_last), 32'(l));
            chk("stall_ready", 32'(s_axis_ready), 32'd0);
        end
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", 32'(m_axis_valid), 32'd0);
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic sw, input int stall);
        push(l, 1'b0, sw, stall);
        push(r, 1'b1, sw, 0);
    endtask

    task automatic check_clear();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("clear_ready", 32'(s_axis_ready), 32'd0);
            chk("clear_valid", 32'(m_axis_valid), 32'd0);
        end
        @(negedge clk);
        chk("clear_done", 32'(s_axis_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'(s_axis_ready), 32'd0);
            chk("rst_valid", 32'(m_axis_valid), 32'd0);
            chk("rst_data", 32'(m_axis_data), 32'd0);
            chk("rst_last", 32'(m_axis_last), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        check_clear();

        // Impulse with echo
        frame(24'h100000, 24'h0, 1'b1, 0);
        for (int f = 0; f < 7; f++) frame(24'h0, 24'h0, 1'b1, 0);

        // Bypass impulse, then echo on with zeros must stay silent
        frame(24'h100000, 24'h0, 1'b0, 0);
        frame(24'h0, 24'h0, 1'b0, 0);
        for (int f = 0; f < 3; f++) frame(24'h0, 24'h0, 1'b1, 0);

        // Saturation positive, negative, and in-range
        frame(24'h0, 24'h0, 1'b0, 0);
        frame(24'h0, 24'h0, 1'b0, 0);
        frame(24'h600000, 24'h0, 1'b1, 0);
        frame(24'h0, 24'h0, 1'b1, 0);
        frame(24'h600000, 24'h0, 1'b1, 0);
        frame(24'h0, 24'h0, 1'b0, 0);
        frame(24'h0, 24'h0, 1'b0, 0);
        frame(24'hA00000, 24'h0, 1'b1, 0);
        frame(24'h0, 24'h0, 1'b1, 0);
        frame(24'hA00000, 24'h0, 1'b1, 0);
        frame(24'h0, 24'h0, 1'b0, 0);
        frame(24'h0, 24'h0, 1'b0, 0);
        frame(24'h200000, 24'h0, 1'b1, 0);
        frame(24'h0, 24'h0, 1'b1, 0);
        frame(24'h200000, 24'h0, 1'b1, 0);

        // Backpressure with input held valid
        frame(24'h0ABCDE, 24'hF12345, 1'b1, 10);
        frame(24'h0, 24'h0, 1'b1, 0);
        frame(24'h0, 24'h0, 1'b1, 0);

        // Randomized traffic
        for (int f = 0; f < 20; f++) begin
            frame(24'($urandom), 24'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
        end

        // Reset while a sample waits in OUT
        s_axis_data  = 24'h123456;
        s_axis_last  = 1'b0;
        echo_sw      = 1'b1;
        s_axis_valid = 1'b1;
        @(posedge clk);
        #1 s_axis_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(m_axis_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(m_axis_valid), 32'd0);
        chk("midrst_ready", 32'(s_axis_ready), 32'd0);
        chk("midrst_data", 32'(m_axis_data), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        hist.delete();
        check_clear();
        for (int f = 0; f < 4; f++) frame(24'h0, 24'h0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
